frec_divider_prog: RTL and testbench
====================================

// Module: frec_divider_prog
// PURPOSE
//  Synchronous, run-time programmable clock-enable divider; next generation of the
//  fixed ripple divide-by-512 that feeds the PWM block. Counts system clk cycles,
//  emits a one-cycle tick every N enabled cycles and a square wave of period 2N.
//  Divisor changes are staged and applied only at a period boundary (glitch-free).
//  All logic runs on clk; outputs are enables/data, never used as clocks.
// PARAMETERS
//  DIV_W        10   width of divisor, counter and div_val
//  DEFAULT_DIV  512  divisor loaded at reset (matches legacy /512 rate)
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      asynchronous, active-low reset
//  en           in   1      count enable; low = freeze
//  div_val      in   DIV_W  new divisor N, sampled on div_load
//  div_load     in   1      one-cycle strobe: stage div_val
//  tick         out  1      registered, high one cycle per period (PWM step enable)
//  clk_out      out  1      registered square wave, toggles on each tick
//  div_pending  out  1      staged divisor not yet applied
//  count        out  DIV_W  current counter value
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, active=shadow=DEFAULT_DIV, tick=0, clk_out=0,
//    div_pending=0. Takes effect immediately, mid-period included; no partial tick.
//  - Effective divisor Neff = (active==0) ? 1 : active. 0 is never a stall.
//  - Each edge with en=1: if count==Neff-1 ("wrap"): count<=0, tick<=1,
//    clk_out<=~clk_out; else count<=count+1, tick<=0.
//  - Edge with en=0: count, clk_out, active hold; tick<=0.
//  - Latency: from reset release with en held high, first tick is high in the cycle
//    after the Neff-th rising edge; thereafter every Neff cycles. clk_out period 2*Neff.
//  - Neff=1: tick stays high continuously while en=1; clk_out = clk/2.
//  - div_load (no wrap same edge): shadow<=div_val, div_pending<=1.
//  - Wrap with div_pending=1 and no div_load: active<=shadow, div_pending<=0;
//    new Neff governs the period starting at count=0.
//  - div_load on the wrap edge: active<=div_val directly, div_pending stays/goes 0;
//    shadow<=div_val. Load wins over old staged value.
//  - Several loads before a wrap: last one wins. div_load accepted regardless of en;
//    with en=0 the change stays pending until the next enabled wrap.
//  - Active value never changes mid-period, so a larger/smaller N cannot truncate or
//    overrun the current period (count < old Neff always when change applies).
//  - count wraps only via the compare; never exceeds Neff-1 and never overflows DIV_W.
// TESTING
//  1 Reset, en=1, DEFAULT_DIV=512 -> tick every 512 cycles, clk_out period 1024,
//    first tick the cycle after edge 512.
//  2 Load 4 mid-period (count=100) -> div_pending=1 until wrap at count 511, then
//    ticks every 4 cycles, pending=0.
//  3 div_val=0 and div_val=1 -> tick held high, clk_out toggles every cycle.
//  4 en pulsed low 3 cycles with N=8 -> count/clk_out frozen, tick period stretches to
//    11 cycles once; load during en=0 stays pending.
//  5 div_load coincident with wrap (N=6 -> 3) -> next period is 3 cycles, pending
//    never asserted; two loads (5 then 7) before wrap -> 7 applied.
//  6 rst asserted at count=300 -> all outputs to reset values asynchronously,
//    active=512 restored, no tick on release.

Source files
------------

// File: rtl/frec_divider_prog.sv
// Programmable clock-enable divider: one-cycle tick every Neff enabled cycles plus a square wave of period 2*Neff.
// Latency: tick is registered; with en held high it is first high in the cycle after the Neff-th rising edge.
// Backpressure: none; en=0 freezes count/clk_out/active, and a staged divisor applies only at an enabled wrap.
module frec_divider_prog #(
  parameter int unsigned DIV_W       = 10,
  parameter int unsigned DEFAULT_DIV = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             tick,
  output logic             clk_out,
  output logic             div_pending,
  output logic [DIV_W-1:0] count
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             pending_q, pending_d;
  logic [DIV_W-1:0] last_cnt;
  logic             wrap;

  // Terminal count: a programmed divisor of 0 behaves as divide-by-1 rather than stalling.
  always_comb begin
    last_cnt = (active_q == '0) ? '0 : (active_q - DIV_W'(1));
    wrap     = en && (count_q == last_cnt);
  end

  // Next-state: count/wrap, tick and square wave, plus staging of divisor changes to the period boundary.
  always_comb begin
    count_d   = count_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;
    pending_d = pending_q;
    if (wrap) begin
      count_d   = '0;
      tick_d    = 1'b1;
      clk_out_d = ~clk_out_q;
      if (div_load) begin
        // A load on the boundary edge takes effect immediately and supersedes any staged value.
        active_d  = div_val;
        shadow_d  = div_val;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else begin
      if (en) begin
        count_d = count_q + DIV_W'(1);
      end
      // Loads are accepted even while frozen; the last one before a wrap wins.
      if (div_load) begin
        shadow_d  = div_val;
        pending_d = 1'b1;
      end
    end
  end

  // State register with asynchronous active-low reset back to the legacy /512 rate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      active_q  <= DEF_DIV;
      shadow_q  <= DEF_DIV;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      pending_q <= pending_d;
    end
  end

  // Outputs are direct register copies.
  always_comb begin
    tick        = tick_q;
    clk_out     = clk_out_q;
    div_pending = pending_q;
    count       = count_q;
  end

endmodule

// File: tb/tb_frec_divider_prog.sv
// Self-checking bench for frec_divider_prog: directed vector table plus hand sequences.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Free-running clock; a watchdog bounds the whole run.
module tb_frec_divider_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic [9:0] div_val;
  logic       div_load;
  logic       tick;
  logic       clk_out;
  logic       div_pending;
  logic [9:0] count;

  int tests_run = 0;
  int tests_failed = 0;

  frec_divider_prog #(.DIV_W(10), .DEFAULT_DIV(512)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_val    (div_val),
    .div_load   (div_load),
    .tick       (tick),
    .clk_out    (clk_out),
    .div_pending(div_pending),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       en;
    logic       ld;
    logic [9:0] val;
    int         cnt;
    logic       tk;
    logic       co;
    logic       pd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic l, input int v, input int c,
                     input logic t, input logic o, input logic p);
    vec_t r;
    r.en = e; r.ld = l; r.val = 10'(v); r.cnt = c; r.tk = t; r.co = o; r.pd = p;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int c, input logic t, input logic o, input logic p);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".tick"}, int'(tick), int'(t));
    chk({tag, ".clk_out"}, int'(clk_out), int'(o));
    chk({tag, ".pending"}, int'(div_pending), int'(p));
  endtask

  initial begin
    // Table: start state count=0, active=4, clk_out=0, pending=0.
    // div 0 and 1 -> continuous tick
    add(1,1,0, 1,0,0,1);
    add(1,0,0, 2,0,0,1);
    add(1,0,0, 3,0,0,1);
    add(1,0,0, 0,1,1,0);
    add(1,0,0, 0,1,0,0);
    add(1,0,0, 0,1,1,0);
    add(1,0,0, 0,1,0,0);
    add(1,1,1, 0,1,1,0);
    add(1,0,0, 0,1,0,0);
    add(1,0,0, 0,1,1,0);
    // load 8 on a wrap edge, one full period
    add(1,1,8, 0,1,0,0);
    for (int i = 1; i <= 7; i++) add(1,0,0, i,0,0,0);
    add(1,0,0, 0,1,1,0);
    // en low 3 cycles with a load of 5 staged while frozen
    add(1,0,0, 1,0,1,0);
    add(1,0,0, 2,0,1,0);
    add(0,1,5, 2,0,1,1);
    add(0,0,0, 2,0,1,1);
    add(0,0,0, 2,0,1,1);
    for (int i = 3; i <= 7; i++) add(1,0,0, i,0,1,1);
    add(1,0,0, 0,1,0,0);
    // N=5 period with 6 staged
    add(1,1,6, 1,0,0,1);
    for (int i = 2; i <= 4; i++) add(1,0,0, i,0,0,1);
    add(1,0,0, 0,1,1,0);
    // N=6 period, load 3 coincident with wrap
    for (int i = 1; i <= 5; i++) add(1,0,0, i,0,1,0);
    add(1,1,3, 0,1,0,0);
    add(1,0,0, 1,0,0,0);
    add(1,0,0, 2,0,0,0);
    add(1,0,0, 0,1,1,0);
    // two loads (5 then 7) before wrap -> 7 applied
    add(1,1,5, 1,0,1,1);
    add(1,1,7, 2,0,1,1);
    add(1,0,0, 0,1,0,0);
    for (int i = 1; i <= 6; i++) add(1,0,0, i,0,0,0);
    add(1,0,0, 0,1,1,0);

    // Reset state (asynchronous, before any clock edge)
    rst = 1'b0; en = 1'b0; div_val = '0; div_load = 1'b0;
    #2;
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0);

    // Default divide-by-512: two full clk_out periods
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    for (int k = 1; k <= 1024; k++) begin
      step();
      chk("def.count", int'(count), k % 512);
      chk("def.tick", int'(tick), (k % 512 == 0) ? 1 : 0);
      chk("def.clk_out", int'(clk_out), (k / 512) % 2);
    end

    // Run to count=100, then load 4 mid-period
    for (int k = 1; k <= 100; k++) step();
    chk("pre_load.count", int'(count), 100);
    div_val = 10'd4; div_load = 1'b1;
    step();
    div_load = 1'b0; div_val = '0;
    chk_all("load4", 101, 1'b0, 1'b0, 1'b1);
    for (int j = 102; j <= 511; j++) begin
      step();
      chk("load4.count", int'(count), j);
      chk("load4.pending", int'(div_pending), 1);
      chk("load4.tick", int'(tick), 0);
    end
    step();
    chk_all("load4_wrap", 0, 1'b1, 1'b1, 1'b0);
    for (int p = 1; p <= 12; p++) begin
      step();
      chk("n4.count", int'(count), p % 4);
      chk("n4.tick", int'(tick), (p % 4 == 0) ? 1 : 0);
      chk("n4.clk_out", int'(clk_out), 1 ^ ((p / 4) % 2));
    end

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; div_load = vecs[i].ld; div_val = vecs[i].val;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].tk, vecs[i].co, vecs[i].pd);
    end
    en = 1'b1; div_load = 1'b0; div_val = '0;

    // Move to N=400 and run to count=300 with clk_out high
    div_val = 10'd400; div_load = 1'b1;
    step();
    div_load = 1'b0; div_val = '0;
    chk("load400.count", int'(count), 1);
    chk("load400.pending", int'(div_pending), 1);
    for (int k = 2; k <= 6; k++) step();
    step();
    chk_all("n7_wrap", 0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 700; k++) begin
      step();
      chk("n400.count", int'(count), k % 400);
      chk("n400.tick", int'(tick), (k == 400) ? 1 : 0);
      chk("n400.clk_out", int'(clk_out), (k >= 400) ? 1 : 0);
    end

    // Asynchronous reset mid-period at count=300
    #3;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk_all("held_rst", 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      step();
      chk("post_rst.count", int'(count), k % 512);
      chk("post_rst.tick", int'(tick), (k == 512) ? 1 : 0);
      chk("post_rst.clk_out", int'(clk_out), (k == 512) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
